// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types and helpers for the clock time-setting block.
//   state_e     : edit FSM states (RUN and one state per edited field)
//   field_e     : field code driven on time_set.field
//   bcd_time_t  : packed BCD hh:mm:ss as held by the set_* registers
//   HOUR_MAX    : largest legal hour value (23)
//   MIN_SEC_MAX : largest legal minute/second value (59)
// Helper functions perform BCD increment with wrap and legality checks.
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam int HOUR_MAX    = 23;
  localparam int MIN_SEC_MAX = 59;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE    = 2'd0,
    FIELD_HOURS   = 2'd1,
    FIELD_MINUTES = 2'd2,
    FIELD_SECONDS = 2'd3
  } field_e;

  typedef struct packed {
    logic [1:0] h_msd;
    logic [3:0] h_lsd;
    logic [2:0] m_msd;
    logic [3:0] m_lsd;
    logic [2:0] s_msd;
    logic [3:0] s_lsd;
  } bcd_time_t;

  function automatic field_e field_of(input state_e s);
    case (s)
      ST_SET_H: return FIELD_HOURS;
      ST_SET_M: return FIELD_MINUTES;
      ST_SET_S: return FIELD_SECONDS;
      default:  return FIELD_NONE;
    endcase
  endfunction

  function automatic logic hour_legal(input logic [1:0] msd, input logic [3:0] lsd);
    return (lsd <= 4'd9) && ((int'(msd) * 10 + int'(lsd)) <= HOUR_MAX);
  endfunction

  function automatic logic min_sec_legal(input logic [2:0] msd, input logic [3:0] lsd);
    return (lsd <= 4'd9) && ((int'(msd) * 10 + int'(lsd)) <= MIN_SEC_MAX);
  endfunction

  // Hours +1 in BCD, wrapping HOUR_MAX -> 00. Any out-of-range input also
  // lands on a legal value, so the register can never drift out of range.
  function automatic logic [5:0] hour_inc(input logic [1:0] msd, input logic [3:0] lsd);
    logic [1:0] m;
    logic [3:0] l;
    m = msd;
    l = lsd;
    if ((int'(msd) * 10 + int'(lsd)) >= HOUR_MAX) begin
      m = 2'd0;
      l = 4'd0;
    end else if (lsd >= 4'd9) begin
      m = msd + 2'd1;
      l = 4'd0;
    end else begin
      l = lsd + 4'd1;
    end
    return {m, l};
  endfunction

  // Minutes +1 in BCD, wrapping MIN_SEC_MAX -> 00.
  function automatic logic [6:0] min_sec_inc(input logic [2:0] msd, input logic [3:0] lsd);
    logic [2:0] m;
    logic [3:0] l;
    m = msd;
    l = lsd;
    if ((int'(msd) * 10 + int'(lsd)) >= MIN_SEC_MAX) begin
      m = 3'd0;
      l = 4'd0;
    end else if (lsd >= 4'd9) begin
      m = msd + 3'd1;
      l = 4'd0;
    end else begin
      l = lsd + 4'd1;
    end
    return {m, l};
  endfunction

  // Snapshot of the running time; an illegal field is replaced by 00 so the
  // edit registers start from a legal value.
  function automatic bcd_time_t capture_time(
    input logic [1:0] h_msd, input logic [3:0] h_lsd,
    input logic [2:0] m_msd, input logic [3:0] m_lsd,
    input logic [2:0] s_msd, input logic [3:0] s_lsd
  );
    bcd_time_t t;
    t = '0;
    if (hour_legal(h_msd, h_lsd)) begin
      t.h_msd = h_msd;
      t.h_lsd = h_lsd;
    end
    if (min_sec_legal(m_msd, m_lsd)) begin
      t.m_msd = m_msd;
      t.m_lsd = m_lsd;
    end
    if (min_sec_legal(s_msd, s_lsd)) begin
      t.s_msd = s_msd;
      t.s_lsd = s_lsd;
    end
    return t;
  endfunction

endpackage

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Button conditioning: 2-FF synchronizer, stability-count debouncer and
// rising-edge detector on the debounced level.
//   clock   : system clock
//   reset   : synchronous, active-high
//   btn_i   : raw asynchronous button, high when pressed
//   press_o : one-cycle pulse on each accepted 0->1 debounced edge
// -----------------------------------------------------------------------------
module debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks how many consecutive synchronized samples have
  // disagreed with the accepted level; any agreeing sample restarts it.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;  // only the 0->1 acceptance is a press
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, exactly like the hardware flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_set.sv
// -----------------------------------------------------------------------------
// time_set
// Two-button time-setting controller for a BCD hh:mm:ss clock.
//   clock, reset       : single clock, synchronous active-high reset
//   enable1hz          : one-cycle pulse per second (timeout and blink)
//   btn_mode, btn_inc  : raw buttons (mode steps fields, inc edits)
//   cur_*              : running time, captured when editing starts
//   set_*              : edited time presented to the counters
//   load               : one-cycle commit pulse after leaving SET_S by mode
//   setting, field     : edit-mode flag and field code, registered
//   blink              : blank request for the edited field
// -----------------------------------------------------------------------------
module time_set
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_S       = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_h_Msd,
  input  logic [3:0] cur_h_Lsd,
  input  logic [2:0] cur_m_Msd,
  input  logic [3:0] cur_m_Lsd,
  input  logic [2:0] cur_s_Msd,
  input  logic [3:0] cur_s_Lsd,
  output logic [1:0] set_h_Msd,
  output logic [3:0] set_h_Lsd,
  output logic [2:0] set_m_Msd,
  output logic [3:0] set_m_Lsd,
  output logic [2:0] set_s_Msd,
  output logic [3:0] set_s_Lsd,
  output logic       load,
  output logic       setting,
  output logic [1:0] field,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);

  logic mode_press, inc_press;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (btn_mode),
    .press_o (mode_press)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (btn_inc),
    .press_o (inc_press)
  );

  state_e          state_q, state_d;
  bcd_time_t       set_q, set_d;
  logic [TW-1:0]   to_q, to_d;
  logic            load_q, load_d;
  logic            blink_q, blink_d;
  logic            setting_q, setting_d;
  field_e          field_q, field_d;

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    to_d    = to_q;
    load_d  = 1'b0;
    blink_d = blink_q;

    if (state_q == ST_RUN) begin
      // inc is ignored here; the set_* registers simply hold.
      to_d    = '0;
      blink_d = 1'b0;
      if (mode_press) begin
        state_d = ST_SET_H;
        set_d   = capture_time(cur_h_Msd, cur_h_Lsd, cur_m_Msd, cur_m_Lsd,
                               cur_s_Msd, cur_s_Lsd);
      end
    end else begin
      // Mode has priority over a coincident inc; either one is an accepted
      // press and restarts the timeout.
      if (mode_press) begin
        to_d = '0;
        case (state_q)
          ST_SET_H: state_d = ST_SET_M;
          ST_SET_M: state_d = ST_SET_S;
          default: begin
            state_d = ST_RUN;
            load_d  = 1'b1;
          end
        endcase
      end else if (inc_press) begin
        to_d = '0;
        case (state_q)
          ST_SET_H: {set_d.h_msd, set_d.h_lsd} = hour_inc(set_q.h_msd, set_q.h_lsd);
          ST_SET_M: {set_d.m_msd, set_d.m_lsd} = min_sec_inc(set_q.m_msd, set_q.m_lsd);
          default: begin
            set_d.s_msd = 3'd0;
            set_d.s_lsd = 4'd0;
          end
        endcase
      end else if (enable1hz) begin
        // The pulse that would bring the count to TIMEOUT_S abandons the
        // edit instead; no load is issued.
        if (to_q == TO_LAST) begin
          state_d = ST_RUN;
          to_d    = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      if (enable1hz) begin
        blink_d = ~blink_q;
      end
      if (state_d == ST_RUN) begin
        blink_d = 1'b0;
      end
    end

    // Flags are registered from the next state so they change on the same
    // edge as the state register itself.
    setting_d = (state_d != ST_RUN);
    field_d   = field_of(state_d);
  end

  // NOTE: reset sits inside the clocked block, so it is synchronous and wins
  // over every other input on that edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RUN;
      set_q     <= '0;
      to_q      <= '0;
      load_q    <= 1'b0;
      blink_q   <= 1'b0;
      setting_q <= 1'b0;
      field_q   <= FIELD_NONE;
    end else begin
      state_q   <= state_d;
      set_q     <= set_d;
      to_q      <= to_d;
      load_q    <= load_d;
      blink_q   <= blink_d;
      setting_q <= setting_d;
      field_q   <= field_d;
    end
  end

  assign set_h_Msd = set_q.h_msd;
  assign set_h_Lsd = set_q.h_lsd;
  assign set_m_Msd = set_q.m_msd;
  assign set_m_Lsd = set_q.m_lsd;
  assign set_s_Msd = set_q.s_msd;
  assign set_s_Lsd = set_q.s_lsd;
  assign load      = load_q;
  assign setting   = setting_q;
  assign field     = field_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_time_set.sv
// -----------------------------------------------------------------------------
// tb_time_set
// Directed bench for time_set with DEBOUNCE_CYCLES=4 and TIMEOUT_S=3.
// A table of button/tick operations with expected outputs is applied in a
// loop, followed by hand-written sequences for timeout, coincident presses
// and reset during an edit. Load pulses are counted by a monitor.
// -----------------------------------------------------------------------------
module tb_time_set;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] cur_h_Msd;
  logic [3:0] cur_h_Lsd;
  logic [2:0] cur_m_Msd;
  logic [3:0] cur_m_Lsd;
  logic [2:0] cur_s_Msd;
  logic [3:0] cur_s_Lsd;
  logic [1:0] set_h_Msd;
  logic [3:0] set_h_Lsd;
  logic [2:0] set_m_Msd;
  logic [3:0] set_m_Lsd;
  logic [2:0] set_s_Msd;
  logic [3:0] set_s_Lsd;
  logic       load, setting, blink;
  logic [1:0] field;

  time_set #(.DEBOUNCE_CYCLES(4), .TIMEOUT_S(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable1hz (enable1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .cur_h_Msd (cur_h_Msd),
    .cur_h_Lsd (cur_h_Lsd),
    .cur_m_Msd (cur_m_Msd),
    .cur_m_Lsd (cur_m_Lsd),
    .cur_s_Msd (cur_s_Msd),
    .cur_s_Lsd (cur_s_Lsd),
    .set_h_Msd (set_h_Msd),
    .set_h_Lsd (set_h_Lsd),
    .set_m_Msd (set_m_Msd),
    .set_m_Lsd (set_m_Lsd),
    .set_s_Msd (set_s_Msd),
    .set_s_Lsd (set_s_Lsd),
    .load      (load),
    .setting   (setting),
    .field     (field),
    .blink     (blink)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;

  always @(negedge clock) begin
    if (load) load_cnt++;
  end

  typedef enum {OP_MODE, OP_INC, OP_BOTH, OP_TICK} op_e;

  typedef struct {
    op_e        op;
    int         reps;
    logic       setting;
    logic [1:0] field;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       blink;
    int         loads;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input op_e op, input int reps, input logic st,
                              input logic [1:0] fld, input logic [7:0] h,
                              input logic [7:0] m, input logic [7:0] s,
                              input logic bl, input int loads);
    vec_t v;
    v.op = op; v.reps = reps; v.setting = st; v.field = fld;
    v.h = h; v.m = m; v.s = s; v.blink = bl; v.loads = loads;
    return v;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    cycles(10);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cycles(10);
  endtask

  task automatic tick();
    enable1hz = 1'b1;
    cycles(1);
    enable1hz = 1'b0;
    cycles(2);
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cur_h_Msd = h[5:4]; cur_h_Lsd = h[3:0];
    cur_m_Msd = m[6:4]; cur_m_Lsd = m[3:0];
    cur_s_Msd = s[6:4]; cur_s_Lsd = s[3:0];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic st, input logic [1:0] fld,
                           input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic bl, input int loads);
    check({tag, " setting"}, 32'(setting), 32'(st));
    check({tag, " field"},   32'(field),   32'(fld));
    check({tag, " set_h"},   32'({2'b00, set_h_Msd, set_h_Lsd}), 32'(h));
    check({tag, " set_m"},   32'({1'b0, set_m_Msd, set_m_Lsd}),  32'(m));
    check({tag, " set_s"},   32'({1'b0, set_s_Msd, set_s_Lsd}),  32'(s));
    check({tag, " blink"},   32'(blink),   32'(bl));
    check({tag, " loads"},   32'(load_cnt), 32'(loads));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_cur(8'h12, 8'h34, 8'h56);

    // Reset state.
    cycles(3);
    check_all("reset", 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    check("reset load", 32'(load), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Bouncing mode button: 2 high, 1 low, then held 10 -> one press only.
    btn_mode = 1'b1; cycles(2);
    btn_mode = 1'b0; cycles(1);
    btn_mode = 1'b1; cycles(10);
    btn_mode = 1'b0; cycles(10);
    check_all("bounce", 1'b1, 2'd1, 8'h12, 8'h34, 8'h56, 1'b0, 0);

    vecs[0]  = mk(OP_INC,  7,  1'b1, 2'd1, 8'h19, 8'h34, 8'h56, 1'b0, 0);
    vecs[1]  = mk(OP_INC,  1,  1'b1, 2'd1, 8'h20, 8'h34, 8'h56, 1'b0, 0);
    vecs[2]  = mk(OP_INC,  2,  1'b1, 2'd1, 8'h22, 8'h34, 8'h56, 1'b0, 0);
    vecs[3]  = mk(OP_INC,  1,  1'b1, 2'd1, 8'h23, 8'h34, 8'h56, 1'b0, 0);
    vecs[4]  = mk(OP_INC,  1,  1'b1, 2'd1, 8'h00, 8'h34, 8'h56, 1'b0, 0);
    vecs[5]  = mk(OP_MODE, 1,  1'b1, 2'd2, 8'h00, 8'h34, 8'h56, 1'b0, 0);
    vecs[6]  = mk(OP_INC,  5,  1'b1, 2'd2, 8'h00, 8'h39, 8'h56, 1'b0, 0);
    vecs[7]  = mk(OP_INC,  1,  1'b1, 2'd2, 8'h00, 8'h40, 8'h56, 1'b0, 0);
    vecs[8]  = mk(OP_INC,  19, 1'b1, 2'd2, 8'h00, 8'h59, 8'h56, 1'b0, 0);
    vecs[9]  = mk(OP_INC,  1,  1'b1, 2'd2, 8'h00, 8'h00, 8'h56, 1'b0, 0);
    vecs[10] = mk(OP_TICK, 1,  1'b1, 2'd2, 8'h00, 8'h00, 8'h56, 1'b1, 0);
    vecs[11] = mk(OP_INC,  1,  1'b1, 2'd2, 8'h00, 8'h01, 8'h56, 1'b1, 0);
    vecs[12] = mk(OP_TICK, 2,  1'b1, 2'd2, 8'h00, 8'h01, 8'h56, 1'b1, 0);
    vecs[13] = mk(OP_MODE, 1,  1'b1, 2'd3, 8'h00, 8'h01, 8'h56, 1'b1, 0);
    vecs[14] = mk(OP_INC,  1,  1'b1, 2'd3, 8'h00, 8'h01, 8'h00, 1'b1, 0);
    vecs[15] = mk(OP_MODE, 1,  1'b0, 2'd0, 8'h00, 8'h01, 8'h00, 1'b0, 1);
    vecs[16] = mk(OP_INC,  1,  1'b0, 2'd0, 8'h00, 8'h01, 8'h00, 1'b0, 1);
    vecs[17] = mk(OP_TICK, 2,  1'b0, 2'd0, 8'h00, 8'h01, 8'h00, 1'b0, 1);

    for (int k = 0; k < NV; k++) begin
      for (int r = 0; r < vecs[k].reps; r++) begin
        case (vecs[k].op)
          OP_MODE: press(1'b1, 1'b0);
          OP_INC:  press(1'b0, 1'b1);
          OP_BOTH: press(1'b1, 1'b1);
          default: tick();
        endcase
      end
      check_all($sformatf("vec%0d", k), vecs[k].setting, vecs[k].field,
                vecs[k].h, vecs[k].m, vecs[k].s, vecs[k].blink, vecs[k].loads);
    end

    // Timeout out of SET_M, plus 09 -> 10 on the way.
    set_cur(8'h09, 8'h15, 8'h42);
    press(1'b1, 1'b0);
    check_all("to_enter", 1'b1, 2'd1, 8'h09, 8'h15, 8'h42, 1'b0, 1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    tick();
    tick();
    check_all("to_wait", 1'b1, 2'd2, 8'h10, 8'h15, 8'h42, 1'b0, 1);
    tick();
    check_all("to_expire", 1'b0, 2'd0, 8'h10, 8'h15, 8'h42, 1'b0, 1);

    // Coincident mode + inc in SET_H: mode wins, hours unchanged.
    set_cur(8'h21, 8'h07, 8'h33);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check_all("both", 1'b1, 2'd2, 8'h21, 8'h07, 8'h33, 1'b0, 1);

    // Reset while in SET_S abandons the edit without a load.
    press(1'b1, 1'b0);
    check("pre_rst field", 32'(field), 32'd3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(1);
    check_all("rst_sets", 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1);
    check("rst_sets load", 32'(load), 32'd0);
    cycles(10);
    check("rst_sets no load", 32'(load_cnt), 32'd1);
    press(1'b1, 1'b0);
    check_all("post_rst", 1'b1, 2'd1, 8'h21, 8'h07, 8'h33, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
